// File: rtl/led_blink_ctrl_pkg.sv
// Shared types and constants for the LED blinker.
// Contents: channel mode enum, register-select codes, CTRL bit positions,
// and a helper that assembles the CTRL read-back word.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } led_mode_t;

    localparam logic SEL_INTERVAL = 1'b0;
    localparam logic SEL_CTRL     = 1'b1;

    localparam int CTRL_MODE_LSB  = 0;
    localparam int CTRL_INV_BIT   = 2;
    localparam int CTRL_BUSY_BIT  = 3;
    localparam int CTRL_BURST_LSB = 8;

    // CTRL read layout: {burst_init, 4'b0, busy, inv, mode}
    function automatic logic [15:0] pack_ctrl(input logic [7:0] burst_init,
                                              input logic       busy,
                                              input logic       inv,
                                              input led_mode_t  mode);
        return {burst_init, 4'b0000, busy, inv, mode};
    endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Peripheral bus bundle for the LED blinker.
// Signals: cs (select), we/rd (strobes qualified by cs), addr {ch, sel},
// wr_data (16b write data), rd_data (16b read data, driven by the slave).
interface led_blink_ctrl_if #(
    parameter int AW = 4
) ();
    logic          cs;
    logic          we;
    logic          rd;
    logic [AW-1:0] addr;
    logic [15:0]   wr_data;
    logic [15:0]   rd_data;

    modport master (output cs, we, rd, addr, wr_data, input rd_data);
    modport slave  (input cs, we, rd, addr, wr_data, output rd_data);
endinterface

// File: rtl/led_blink_ctrl_chan.sv
// One blink channel: tick-driven half-period counter, phase flop and burst
// counter.
// Ports: clk, rst (async active-low), tick (shared prescaler strobe),
// wr_int / wr_ctrl (this channel's register is written this cycle),
// burst_init (burst count being loaded by a CTRL write), interval, mode,
// phase (LED phase flop), busy (burst still running).
module blink_chan
    import led_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        wr_int,
    input  logic        wr_ctrl,
    input  logic [7:0]  burst_init,
    input  logic [15:0] interval,
    input  led_mode_t   mode,
    output logic        phase,
    output logic        busy
);
    logic [15:0] count_q, count_d;
    logic [7:0]  rem_q, rem_d;
    logic        phase_q, phase_d;
    logic        period_end_s;

    // Last tick of a half-period; widened so that interval-1 can never wrap.
    assign period_end_s = ({1'b0, count_q} + 17'd1) >= {1'b0, interval};

    // Next-state: a register write always wins over a coincident tick.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        if (wr_ctrl) begin
            count_d = 16'd0;
            phase_d = 1'b0;
            rem_d   = burst_init;
        end else if (wr_int) begin
            count_d = 16'd0;
        end else if (tick) begin
            case (mode)
                MODE_OFF: begin
                    phase_d = 1'b0;
                    count_d = 16'd0;
                end
                MODE_ON: begin
                    phase_d = 1'b1;
                    count_d = 16'd0;
                end
                MODE_BLINK: begin
                    if (interval == 16'd0) begin
                        phase_d = 1'b0;
                        count_d = 16'd0;
                    end else if (period_end_s) begin
                        count_d = 16'd0;
                        phase_d = ~phase_q;
                    end else begin
                        count_d = count_q + 16'd1;
                    end
                end
                MODE_BURST: begin
                    if ((rem_q == 8'd0) || (interval == 16'd0)) begin
                        phase_d = 1'b0;
                        count_d = 16'd0;
                    end else if (period_end_s) begin
                        count_d = 16'd0;
                        phase_d = ~phase_q;
                        // A pulse completes on its falling edge.
                        if (phase_q) begin
                            rem_d = rem_q - 8'd1;
                        end else begin
                            rem_d = rem_q;
                        end
                    end else begin
                        count_d = count_q + 16'd1;
                    end
                end
                default: begin
                    phase_d = 1'b0;
                    count_d = 16'd0;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'd0;
            rem_q   <= 8'd0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign busy  = (mode == MODE_BURST) && (rem_q != 8'd0);

endmodule

// File: rtl/led_blink_ctrl.sv
// N-channel memory-mapped LED blinker.
// Ports: clk, rst (async active-low), bus (slave side of led_blink_ctrl_if:
// cs/we/rd/addr/wr_data in, combinational rd_data out), led_out (bit i =
// channel i, phase ^ inv straight from flops).
// Holds the shared tick prescaler, the INTERVAL/CTRL register file, the
// address decode and the read mux; per-channel timing lives in blink_chan.
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int N_CH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    led_blink_ctrl_if.slave      bus,
    output logic [N_CH-1:0]      led_out
);
    localparam int AW       = $clog2(N_CH) + 1;
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);

    logic [PW-1:0]   pre_q;
    logic            tick_q;
    logic [AW-1:0]   ch_s;
    logic            sel_s;
    logic            wr_s;
    logic [15:0]     interval_q [N_CH];
    led_mode_t       mode_q     [N_CH];
    logic [7:0]      binit_q    [N_CH];
    logic [N_CH-1:0] inv_q;
    logic [N_CH-1:0] wr_int_s;
    logic [N_CH-1:0] wr_ctrl_s;
    logic [N_CH-1:0] phase_s;
    logic [N_CH-1:0] busy_s;

    assign sel_s = bus.addr[0];
    assign ch_s  = bus.addr >> 1;
    assign wr_s  = bus.cs && bus.we;

    // Prescaler; tick is registered so it is high exactly while pre_q is at its top count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            if (pre_q == PW'(TICK_DIV - 1)) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
            tick_q <= (pre_q == PW'(TICK_DIV - 2));
        end
    end

    // Per-channel write strobes; addresses beyond N_CH match nothing.
    always_comb begin
        wr_int_s  = '0;
        wr_ctrl_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_s && (ch_s == AW'(i))) begin
                wr_ctrl_s[i] = (sel_s == SEL_CTRL);
                wr_int_s[i]  = (sel_s == SEL_INTERVAL);
            end else begin
                wr_ctrl_s[i] = 1'b0;
                wr_int_s[i]  = 1'b0;
            end
        end
    end

    // Register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                interval_q[i] <= 16'd0;
                mode_q[i]     <= MODE_OFF;
                binit_q[i]    <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_int_s[i]) begin
                    interval_q[i] <= bus.wr_data;
                end
                if (wr_ctrl_s[i]) begin
                    mode_q[i]  <= led_mode_t'(bus.wr_data[CTRL_MODE_LSB +: 2]);
                    inv_q[i]   <= bus.wr_data[CTRL_INV_BIT];
                    binit_q[i] <= bus.wr_data[CTRL_BURST_LSB +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        blink_chan u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_q),
            .wr_int     (wr_int_s[g]),
            .wr_ctrl    (wr_ctrl_s[g]),
            .burst_init (bus.wr_data[CTRL_BURST_LSB +: 8]),
            .interval   (interval_q[g]),
            .mode       (mode_q[g]),
            .phase      (phase_s[g]),
            .busy       (busy_s[g])
        );
    end

    assign led_out = phase_s ^ inv_q;

    // Combinational read mux; returns pre-write values when a write coincides.
    always_comb begin
        bus.rd_data = 16'd0;
        if (bus.cs && bus.rd) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_s == AW'(i)) begin
                    bus.rd_data = (sel_s == SEL_CTRL)
                                ? pack_ctrl(binit_q[i], busy_s[i], inv_q[i], mode_q[i])
                                : interval_q[i];
                end else begin
                    bus.rd_data = bus.rd_data;
                end
            end
        end else begin
            bus.rd_data = 16'd0;
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl (TICK_DIV=10, 4 channels).
// The stimulus task drives one bus cycle, pushes the expected LED vector and
// any expected read data, then advances a behavioural model; a monitor pops
// and compares on the falling edge.
module tb_led_blink_ctrl;
    localparam int CLK_FREQ = 10_000;
    localparam int TICK_HZ  = 1000;
    localparam int N_CH     = 4;
    localparam int AW       = 3;
    localparam int TDIV     = CLK_FREQ / TICK_HZ;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N_CH-1:0] led_out;

    led_blink_ctrl_if #(.AW(AW)) bus ();

    led_blink_ctrl #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .N_CH(N_CH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [N_CH-1:0] led_exp_q [$];
    logic [15:0]     rd_exp_q  [$];

    // Behavioural model: registers, LED phase, ticks into current half-period,
    // pulses left, clocks since reset.
    logic [15:0] m_int   [N_CH];
    logic [1:0]  m_mode  [N_CH];
    logic [7:0]  m_binit [N_CH];
    bit          m_inv   [N_CH];
    bit          m_ph    [N_CH];
    int          m_n     [N_CH];
    int          m_rem   [N_CH];
    int          m_c;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_int[i] = 16'd0; m_mode[i] = 2'd0; m_binit[i] = 8'd0;
            m_inv[i] = 1'b0;  m_ph[i] = 1'b0;   m_n[i] = 0; m_rem[i] = 0;
        end
        m_c = 0;
    endtask

    function automatic logic [N_CH-1:0] m_led();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = m_ph[i] ^ m_inv[i];
        return v;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        int  ch;
        bit  busy;
        ch = int'(a[2:1]);
        if (a[0] == 1'b0) return m_int[ch];
        busy = (m_mode[ch] == 2'd3) && (m_rem[ch] != 0);
        return {m_binit[ch], 4'b0000, busy, m_inv[ch], m_mode[ch]};
    endfunction

    // One tick worth of behaviour for a channel, stated in terms of the mode rules.
    task automatic m_tick(input int ch);
        case (m_mode[ch])
            2'd0: begin m_ph[ch] = 1'b0; m_n[ch] = 0; end
            2'd1: begin m_ph[ch] = 1'b1; m_n[ch] = 0; end
            2'd2: begin
                if (m_int[ch] == 16'd0) begin
                    m_ph[ch] = 1'b0; m_n[ch] = 0;
                end else begin
                    m_n[ch]++;
                    if (m_n[ch] >= int'(m_int[ch])) begin m_ph[ch] = ~m_ph[ch]; m_n[ch] = 0; end
                end
            end
            default: begin
                if (m_rem[ch] == 0 || m_int[ch] == 16'd0) begin
                    m_ph[ch] = 1'b0; m_n[ch] = 0;
                end else begin
                    m_n[ch]++;
                    if (m_n[ch] >= int'(m_int[ch])) begin
                        if (m_ph[ch]) m_rem[ch]--;
                        m_ph[ch] = ~m_ph[ch];
                        m_n[ch]  = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic model_advance(input bit wr, input logic [2:0] a, input logic [15:0] d);
        bit tick;
        int wch;
        tick = (m_c % TDIV) == (TDIV - 1);
        wch  = -1;
        if (wr) begin
            wch = int'(a[2:1]);
            if (a[0]) begin
                m_mode[wch] = d[1:0]; m_inv[wch] = d[2]; m_binit[wch] = d[15:8];
                m_ph[wch] = 1'b0; m_n[wch] = 0; m_rem[wch] = int'(d[15:8]);
            end else begin
                m_int[wch] = d; m_n[wch] = 0;
            end
        end
        if (tick) begin
            for (int i = 0; i < N_CH; i++) if (i != wch) m_tick(i);
        end
        m_c++;
    endtask

    // One bus cycle: drive just after the rising edge, queue expectations, advance model.
    task automatic cyc(input bit r, input bit cs, input bit we, input bit rd,
                       input logic [2:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = r; bus.cs = cs; bus.we = we; bus.rd = rd; bus.addr = a; bus.wr_data = d;
        if (!r) begin
            model_reset();
            led_exp_q.push_back('0);
            if (rd) rd_exp_q.push_back(16'h0000);
        end else begin
            if (rd) rd_exp_q.push_back(cs ? m_read(a) : 16'h0000);
            led_exp_q.push_back(m_led());
            model_advance(cs && we, a, d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    // Monitor: compare whatever the DUT presents on the falling edge.
    initial begin
        logic [N_CH-1:0] le;
        logic [15:0]     re;
        forever begin
            @(negedge clk);
            if (led_exp_q.size() > 0) begin
                le = led_exp_q.pop_front();
                chk("led_out", 16'(led_out), 16'(le));
            end
            if (bus.rd === 1'b1) begin
                if (rd_exp_q.size() > 0) begin
                    re = rd_exp_q.pop_front();
                    chk("rd_data", bus.rd_data, re);
                end else begin
                    chk("rd_queue_empty", bus.rd_data, 16'hxxxx);
                end
            end
        end
    end

    initial begin
        int rises;
        bit prev;
        int r;
        logic [2:0]  ra;
        logic [15:0] rdv;
        bus.cs = 1'b0; bus.we = 1'b0; bus.rd = 1'b0; bus.addr = 3'd0; bus.wr_data = 16'h0000;
        model_reset();

        // Reset, then every address reads zero; rd without cs reads zero.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        for (int a = 0; a < 8; a++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'(a), 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0000);

        // ch0 blink at interval 3, then retime to 5 mid-period.
        wr(3'd0, 16'd3);
        wr(3'd1, 16'h0002);
        idle(105);
        wr(3'd0, 16'd5);
        idle(160);

        // ch1 steady on, inverted on, inverted off.
        wr(3'd3, 16'h0001); idle(3);
        wr(3'd3, 16'h0005); idle(3);
        wr(3'd3, 16'h0004); idle(3);

        // ch2 burst of two at interval 2, polling CTRL throughout.
        wr(3'd4, 16'd2);
        wr(3'd5, 16'h0203);
        rises = 0;
        prev  = led_out[2];
        for (int i = 0; i < 120; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0000);
            if (led_out[2] && !prev) rises++;
            prev = led_out[2];
        end
        chk("burst_pulse_count", 16'(rises), 16'd2);

        // ch3 blink with interval 0 stays dark; then a CTRL write landing on a tick.
        wr(3'd6, 16'd0);
        wr(3'd7, 16'h0002);
        idle(200);
        wr(3'd6, 16'd1);
        idle(25);
        while ((m_c % TDIV) != (TDIV - 1)) idle(1);
        wr(3'd7, 16'h0002);
        idle(30);

        // Reset in the middle of a burst on ch2.
        wr(3'd5, 16'h0503);
        idle(35);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0000);
        idle(100);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 199));
            ra = 3'($urandom_range(0, 7));
            if (r < 12) begin
                if (ra[0]) begin
                    rdv = 16'($urandom);
                    rdv[15:8] = 8'($urandom_range(0, 3));
                end else begin
                    rdv = 16'($urandom_range(0, 4));
                end
                cyc(1'b1, 1'b1, 1'b1, ($urandom_range(0, 1) == 1), ra, rdv);
            end else if (r < 40) begin
                cyc(1'b1, ($urandom_range(0, 3) != 0), 1'b0, 1'b1, ra, 16'h0000);
            end else if (r == 199) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
            end else begin
                idle(1);
            end
        end

        idle(2);
        @(negedge clk);
        #1;
        chk("led_queue_drained", 16'(led_exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
